// File: rtl/rv_decode_pkg.sv
// Shared types and constants for the RV32I decode stage and its ID/EX register.
package rv_decode_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned PC_W   = 16;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_R, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_type_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    branch;
        logic    jump;
        logic    illegal;
        alu_op_t alu_op;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus4;
        logic [2:0]        funct3;
        ctrl_t             ctrl;
    } idex_t;

    // funct3 to ALU op; sub/sra select the alternate encodings where legal
    function automatic alu_op_t alu_from_funct(input logic [2:0] funct3,
                                               input logic sub, input logic sra);
        case (funct3)
            3'd0:    return sub ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return sra ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/reg_file_32x32.sv
// 32x32 register file: synchronous write, combinational read, x0 hardwired, write-through.
module reg_file_32x32
    import rv_decode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [REG_AW-1:0] raddr1,
    input  logic [REG_AW-1:0] raddr2,
    output logic [XLEN-1:0]   rdata1,
    output logic [XLEN-1:0]   rdata2
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && waddr != '0) begin
            regs[waddr] <= wdata;
        end
    end

    // Same-cycle write-back bypasses the array so decode sees the newest value
    always_comb begin
        if (raddr1 == '0)                    rdata1 = '0;
        else if (we && waddr == raddr1)      rdata1 = wdata;
        else                                 rdata1 = regs[raddr1];
        if (raddr2 == '0)                    rdata2 = '0;
        else if (we && waddr == raddr2)      rdata2 = wdata;
        else                                 rdata2 = regs[raddr2];
    end

endmodule

// File: rtl/instruction_decode_pipeline.sv
// RV32I decode stage: control decode, immediate generation, register read,
// load-use detection and the ID/EX pipeline register.
module instruction_decode_pipeline
    import rv_decode_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   instr_D,
    input  logic [PC_W-1:0]   pc_D,
    input  logic [PC_W-1:0]   pc_plus4D,
    input  logic              wb_en_W,
    input  logic [REG_AW-1:0] wb_rd_W,
    input  logic [XLEN-1:0]   wb_data_W,
    input  logic              flush_E,
    output logic              load_use_stall,
    output logic [XLEN-1:0]   rs1_data_E,
    output logic [XLEN-1:0]   rs2_data_E,
    output logic [XLEN-1:0]   imm_E,
    output logic [REG_AW-1:0] rs1_E,
    output logic [REG_AW-1:0] rs2_E,
    output logic [REG_AW-1:0] rd_E,
    output logic [PC_W-1:0]   pc_E,
    output logic [PC_W-1:0]   pc_plus4E,
    output logic [2:0]        funct3_E,
    output logic [3:0]        alu_op_E,
    output logic              reg_write_E,
    output logic              mem_read_E,
    output logic              mem_write_E,
    output logic              mem_to_reg_E,
    output logic              alu_src_E,
    output logic              branch_E,
    output logic              jump_E,
    output logic              illegal_E
);

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              alt;
    logic [REG_AW-1:0] rs1_field, rs2_field, rs1_idx, rs2_idx;
    logic [XLEN-1:0]   rs1_data, rs2_data, imm;
    logic              rs1_used, rs2_used;
    ctrl_t             ctrl;
    imm_type_t         imm_type;
    idex_t             next, idex;

    assign opcode    = instr_D[6:0];
    assign funct3    = instr_D[14:12];
    assign alt       = instr_D[30];
    assign rs1_field = instr_D[19:15];
    assign rs2_field = instr_D[24:20];

    // Control decode; unknown opcodes flag illegal, an all-zero word is a plain bubble
    always_comb begin
        ctrl     = '0;
        imm_type = IMM_R;
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1; ctrl.alu_op = ALU_PASSB;
                imm_type = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                imm_type = IMM_U;
            end
            OPC_JAL: begin
                ctrl.reg_write = 1'b1; ctrl.jump = 1'b1;
                imm_type = IMM_J;
            end
            OPC_JALR: begin
                ctrl.reg_write = 1'b1; ctrl.jump = 1'b1; ctrl.alu_src = 1'b1;
                imm_type = IMM_I; rs1_used = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl.branch = 1'b1; ctrl.alu_op = ALU_SUB;
                imm_type = IMM_B; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_LOAD: begin
                ctrl.reg_write = 1'b1; ctrl.mem_read = 1'b1;
                ctrl.mem_to_reg = 1'b1; ctrl.alu_src = 1'b1;
                imm_type = IMM_I; rs1_used = 1'b1;
            end
            OPC_STORE: begin
                ctrl.mem_write = 1'b1; ctrl.alu_src = 1'b1;
                imm_type = IMM_S; rs1_used = 1'b1; rs2_used = 1'b1;
            end
            OPC_OP_IMM: begin
                ctrl.reg_write = 1'b1; ctrl.alu_src = 1'b1;
                ctrl.alu_op = alu_from_funct(funct3, 1'b0, alt);
                imm_type = IMM_I; rs1_used = 1'b1;
            end
            OPC_OP: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op = alu_from_funct(funct3, alt, alt);
                rs1_used = 1'b1; rs2_used = 1'b1;
            end
            default: ctrl.illegal = (instr_D != '0);
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{instr_D[31]}}, instr_D[31:20]};
            IMM_S:   imm = {{20{instr_D[31]}}, instr_D[31:25], instr_D[11:7]};
            IMM_B:   imm = {{19{instr_D[31]}}, instr_D[31], instr_D[7],
                            instr_D[30:25], instr_D[11:8], 1'b0};
            IMM_U:   imm = {instr_D[31:12], 12'b0};
            IMM_J:   imm = {{11{instr_D[31]}}, instr_D[31], instr_D[19:12],
                            instr_D[20], instr_D[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign rs1_idx = rs1_used ? rs1_field : '0;
    assign rs2_idx = rs2_used ? rs2_field : '0;

    reg_file_32x32 u_reg_file (
        .clk    (clk),
        .reset  (reset),
        .we     (wb_en_W),
        .waddr  (wb_rd_W),
        .wdata  (wb_data_W),
        .raddr1 (rs1_idx),
        .raddr2 (rs2_idx),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data)
    );

    assign load_use_stall = idex.ctrl.mem_read && (idex.rd != '0) &&
                            ((rs1_used && rs1_field == idex.rd) ||
                             (rs2_used && rs2_field == idex.rd));

    always_comb begin
        next          = '0;
        next.rs1_data = rs1_data;
        next.rs2_data = rs2_data;
        next.imm      = imm;
        next.rs1      = rs1_idx;
        next.rs2      = rs2_idx;
        next.rd       = instr_D[11:7];
        next.pc       = pc_D;
        next.pc_plus4 = pc_plus4D;
        next.funct3   = funct3;
        next.ctrl     = ctrl;
    end

    // Reset, flush and load-use stall all insert a zero bubble
    always_ff @(posedge clk) begin
        if (reset || flush_E || load_use_stall) idex <= '0;
        else                                    idex <= next;
    end

    assign rs1_data_E   = idex.rs1_data;
    assign rs2_data_E   = idex.rs2_data;
    assign imm_E        = idex.imm;
    assign rs1_E        = idex.rs1;
    assign rs2_E        = idex.rs2;
    assign rd_E         = idex.rd;
    assign pc_E         = idex.pc;
    assign pc_plus4E    = idex.pc_plus4;
    assign funct3_E     = idex.funct3;
    assign alu_op_E     = idex.ctrl.alu_op;
    assign reg_write_E  = idex.ctrl.reg_write;
    assign mem_read_E   = idex.ctrl.mem_read;
    assign mem_write_E  = idex.ctrl.mem_write;
    assign mem_to_reg_E = idex.ctrl.mem_to_reg;
    assign alu_src_E    = idex.ctrl.alu_src;
    assign branch_E     = idex.ctrl.branch;
    assign jump_E       = idex.ctrl.jump;
    assign illegal_E    = idex.ctrl.illegal;

endmodule

// File: tb/tb_instruction_decode_pipeline.sv
// Random and directed stimulus for the decode stage, checked against an
// instruction-level reference model of decode, register file and ID/EX.
module tb_instruction_decode_pipeline;

    logic        clk = 1'b0;
    logic        reset, wb_en_W, flush_E, load_use_stall;
    logic [31:0] instr_D, wb_data_W, rs1_data_E, rs2_data_E, imm_E;
    logic [15:0] pc_D, pc_plus4D, pc_E, pc_plus4E;
    logic [4:0]  wb_rd_W, rs1_E, rs2_E, rd_E;
    logic [2:0]  funct3_E;
    logic [3:0]  alu_op_E;
    logic        reg_write_E, mem_read_E, mem_write_E, mem_to_reg_E;
    logic        alu_src_E, branch_E, jump_E, illegal_E;

    always #5 clk = ~clk;

    instruction_decode_pipeline dut (
        .clk(clk), .reset(reset), .instr_D(instr_D), .pc_D(pc_D), .pc_plus4D(pc_plus4D),
        .wb_en_W(wb_en_W), .wb_rd_W(wb_rd_W), .wb_data_W(wb_data_W), .flush_E(flush_E),
        .load_use_stall(load_use_stall), .rs1_data_E(rs1_data_E), .rs2_data_E(rs2_data_E),
        .imm_E(imm_E), .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E), .pc_E(pc_E),
        .pc_plus4E(pc_plus4E), .funct3_E(funct3_E), .alu_op_E(alu_op_E),
        .reg_write_E(reg_write_E), .mem_read_E(mem_read_E), .mem_write_E(mem_write_E),
        .mem_to_reg_E(mem_to_reg_E), .alu_src_E(alu_src_E), .branch_E(branch_E),
        .jump_E(jump_E), .illegal_E(illegal_E)
    );

    typedef struct packed {
        logic [31:0] rs1d, rs2d, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [15:0] pc, pc4;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        rw, mr, mw, m2r, asrc, br, jmp, ill;
    } exp_t;

    // ALU code for each funct3 (ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND); SUB/SRA are the next codes up
    int unsigned f3_map [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

    logic [31:0] m_regs [32];
    exp_t        m_e;
    bit          m_stall;
    logic        obs_stall;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_reg(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (wb_en_W && wb_rd_W == idx) return wb_data_W;
        return m_regs[idx];
    endfunction

    function automatic void model_decode(input logic [31:0] ins, output exp_t d,
                                         output bit u1, output bit u2);
        longint imm = 0;
        longint s   = ins[31] ? 1 : 0;
        d = '0; u1 = 0; u2 = 0;
        case (ins[6:0])
            7'h37: begin d.rw = 1; d.asrc = 1; d.alu = 4'd10; imm = longint'(ins[31:12]) * 4096; end
            7'h17: begin d.rw = 1; d.asrc = 1; imm = longint'(ins[31:12]) * 4096; end
            7'h6F: begin
                d.rw = 1; d.jmp = 1;
                imm = -s * (1 << 20) + longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048
                      + longint'(ins[30:21]) * 2;
            end
            7'h67: begin d.rw = 1; d.jmp = 1; d.asrc = 1; u1 = 1; imm = -s * 2048 + longint'(ins[30:20]); end
            7'h63: begin
                d.br = 1; d.alu = 4'd1; u1 = 1; u2 = 1;
                imm = -s * 4096 + longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32
                      + longint'(ins[11:8]) * 2;
            end
            7'h03: begin
                d.rw = 1; d.mr = 1; d.m2r = 1; d.asrc = 1; u1 = 1;
                imm = -s * 2048 + longint'(ins[30:20]);
            end
            7'h23: begin
                d.mw = 1; d.asrc = 1; u1 = 1; u2 = 1;
                imm = -s * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:7]);
            end
            7'h13: begin
                d.rw = 1; d.asrc = 1; u1 = 1; imm = -s * 2048 + longint'(ins[30:20]);
                d.alu = 4'(f3_map[ins[14:12]] + ((ins[14:12] == 5 && ins[30]) ? 1 : 0));
            end
            7'h33: begin
                d.rw = 1; u1 = 1; u2 = 1;
                d.alu = 4'(f3_map[ins[14:12]] +
                           (((ins[14:12] == 0 || ins[14:12] == 5) && ins[30]) ? 1 : 0));
            end
            default: d.ill = (ins != 0);
        endcase
        d.imm  = 32'(imm);
        d.rd   = ins[11:7];
        d.f3   = ins[14:12];
        d.pc   = pc_D;
        d.pc4  = pc_plus4D;
        d.rs1  = u1 ? ins[19:15] : 5'd0;
        d.rs2  = u2 ? ins[24:20] : 5'd0;
        d.rs1d = rd_reg(d.rs1);
        d.rs2d = rd_reg(d.rs2);
    endfunction

    task automatic compare_e();
        check("rs1_data_E", rs1_data_E, m_e.rs1d);
        check("rs2_data_E", rs2_data_E, m_e.rs2d);
        check("imm_E", imm_E, m_e.imm);
        check("rs1_E", 32'(rs1_E), 32'(m_e.rs1));
        check("rs2_E", 32'(rs2_E), 32'(m_e.rs2));
        check("rd_E", 32'(rd_E), 32'(m_e.rd));
        check("pc_E", 32'(pc_E), 32'(m_e.pc));
        check("pc_plus4E", 32'(pc_plus4E), 32'(m_e.pc4));
        check("funct3_E", 32'(funct3_E), 32'(m_e.f3));
        check("alu_op_E", 32'(alu_op_E), 32'(m_e.alu));
        check("ctrl_E", 32'({reg_write_E, mem_read_E, mem_write_E, mem_to_reg_E,
                             alu_src_E, branch_E, jump_E, illegal_E}),
              32'({m_e.rw, m_e.mr, m_e.mw, m_e.m2r, m_e.asrc, m_e.br, m_e.jmp, m_e.ill}));
    endtask

    // One cycle: drive at negedge, check stall, advance model at posedge, check E
    task automatic step(input logic [31:0] ins, input logic rst, input logic wen,
                        input logic [4:0] wrd, input logic [31:0] wd, input logic fl);
        exp_t d;
        bit   u1, u2;
        @(negedge clk);
        instr_D = ins; reset = rst; wb_en_W = wen; wb_rd_W = wrd; wb_data_W = wd; flush_E = fl;
        pc_D = 16'($urandom); pc_plus4D = pc_D + 16'd4;
        #1;
        model_decode(ins, d, u1, u2);
        m_stall = m_e.mr && m_e.rd != 0 && ((u1 && ins[19:15] == m_e.rd) ||
                                            (u2 && ins[24:20] == m_e.rd));
        obs_stall = load_use_stall;
        if (!rst) check("load_use_stall", 32'(obs_stall), 32'(m_stall));
        @(posedge clk);
        if (rst) begin
            m_e = '0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else begin
            m_e = (fl || m_stall) ? '0 : d;
            if (wen && wrd != 0) m_regs[wrd] = wd;
        end
        #1;
        compare_e();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opc [9] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        logic [6:0]  bad [4] = '{7'h7F, 7'h0F, 7'h73, 7'h00};
        logic [31:0] r = $urandom;
        int unsigned k = $urandom_range(0, 12);
        if (k == 12) return 32'h0;
        r[24:20] = 5'($urandom_range(0, 7));
        r[19:15] = 5'($urandom_range(0, 7));
        r[11:7]  = 5'($urandom_range(0, 7));
        if (k >= 9) r[6:0] = bad[$urandom_range(0, 3)];
        else if (k == 8 && $urandom_range(0, 1) == 1) r[6:0] = 7'h03;
        else r[6:0] = opc[k];
        return r;
    endfunction

    initial begin
        logic [31:0] ins;
        m_e = '0; m_stall = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        instr_D = 0; reset = 1; wb_en_W = 0; wb_rd_W = 0; wb_data_W = 0; flush_E = 0;
        pc_D = 0; pc_plus4D = 0;

        step(32'h0, 1, 1, 5'd3, 32'h55, 0);
        step(32'h0, 1, 0, 5'd0, 32'h0, 0);
        check("reset_imm_E", imm_E, 32'h0);
        check("reset_reg_write_E", 32'(reg_write_E), 32'h0);
        step(32'h0, 0, 0, 5'd0, 32'h0, 0);
        check("reset_stall", 32'(obs_stall), 32'h0);
        for (int i = 1; i < 32; i++) begin
            step({7'h0, 5'd0, 5'(i), 3'd0, 5'd0, 7'h33}, 0, 0, 5'd0, 32'h0, 0);
            check("reset_reg_zero", rs1_data_E, 32'h0);
        end

        step(32'h00028333, 0, 1, 5'd5, 32'hDEADBEEF, 0);
        check("wt_rs1_data", rs1_data_E, 32'hDEADBEEF);
        check("wt_alu_add", 32'(alu_op_E), 32'h0);

        step(32'h0, 0, 1, 5'd0, 32'h1234, 0);
        step(32'hFFF00093, 0, 0, 5'd0, 32'h0, 0);
        check("x0_rs1_data", rs1_data_E, 32'h0);
        check("x0_imm", imm_E, 32'hFFFFFFFF);

        step(32'h00012183, 0, 0, 5'd0, 32'h0, 0);
        step(32'h00118233, 0, 0, 5'd0, 32'h0, 0);
        check("lu_stall", 32'(obs_stall), 32'h1);
        check("lu_bubble_rw", 32'(reg_write_E), 32'h0);
        check("lu_bubble_rd", 32'(rd_E), 32'h0);
        step(32'h00118233, 0, 0, 5'd0, 32'h0, 0);
        check("lu_released", 32'(obs_stall), 32'h0);
        check("lu_add_rd", 32'(rd_E), 32'h4);

        step(32'h00012183, 0, 0, 5'd0, 32'h0, 0);
        step(32'h00118233, 0, 0, 5'd0, 32'h0, 1);
        check("fl_stall", 32'(obs_stall), 32'h1);
        check("fl_bubble_rw", 32'(reg_write_E), 32'h0);

        step(32'hFE000EE3, 0, 0, 5'd0, 32'h0, 0);
        check("beq_imm", imm_E, 32'hFFFFFFFC);
        check("beq_branch", 32'(branch_E), 32'h1);
        step(32'hFFDFF0EF, 0, 0, 5'd0, 32'h0, 0);
        check("jal_imm", imm_E, 32'hFFFFFFFC);
        check("jal_jump", 32'(jump_E), 32'h1);
        step(32'hABCDE3B7, 0, 0, 5'd0, 32'h0, 0);
        check("lui_imm", imm_E, 32'hABCDE000);
        step(32'h0000007F, 0, 0, 5'd0, 32'h0, 0);
        check("illegal_flag", 32'(illegal_E), 32'h1);
        check("illegal_rw", 32'(reg_write_E), 32'h0);

        ins = rand_instr();
        for (int n = 0; n < 600; n++) begin
            if (!m_stall) ins = rand_instr();
            step(ins, ($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                 5'($urandom_range(0, 9)), $urandom, ($urandom_range(0, 9) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
